// File: rtl/edge_pulse_pkg.sv
// rtl/edge_pulse_pkg.sv - mode encodings and edge-select helper for edge_pulse_gen (EDGE_PULSE_CNT_EN sizes the event counters)
package edge_pulse_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_NONE = 2'b00;
   localparam mode_t MODE_RISE = 2'b01;
   localparam mode_t MODE_FALL = 2'b10;
   localparam mode_t MODE_BOTH = 2'b11;

   // Event counter geometry, used only when EDGE_PULSE_CNT_EN is defined
   localparam int              EVT_W   = 8;
   localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};
   localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);

   // Qualify raw rise/fall indications against the selected edge mode
   function automatic logic edge_match(input mode_t mode, input logic rise, input logic fall);
      logic hit;
      case (mode)
         MODE_RISE: hit = rise;
         MODE_FALL: hit = fall;
         MODE_BOTH: hit = rise | fall;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/edge_pulse_ch.sv
// rtl/edge_pulse_ch.sv - one channel: synchroniser, edge detector, retriggerable pulse counter, optional event counter (EDGE_PULSE_CNT_EN)
module edge_pulse_ch
   import edge_pulse_pkg::*;
#(
   parameter int SYNC = 2,
   parameter int PW   = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  mode_t            mode_i,
   input  logic             in_i,
`ifdef EDGE_PULSE_CNT_EN
   input  logic             cnt_clr_i,
   output logic [EVT_W-1:0] evt_cnt_o,
`endif
   output logic             out_o
);

   localparam int            CW    = $clog2(PW + 1);
   localparam logic [CW-1:0] PW_C  = CW'(PW);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   logic [SYNC-1:0] sync_q;
   logic            prev_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic            out_q;
   logic            sync_lvl;
   logic            rise;
   logic            fall;
   logic            det;

   assign sync_lvl = sync_q[SYNC-1];
   assign rise     = sync_lvl & ~prev_q;
   assign fall     = ~sync_lvl & prev_q;
   assign det      = en_i & edge_match(mode_i, rise, fall);

   // Synchroniser chain and history flop keep tracking the input even while detection is disabled
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC-2:0], in_i};
         prev_q <= sync_lvl;
      end
   end

   // Width counter next state: reload on any detection (retrigger), otherwise count down and stop at zero
   always_comb begin
      cnt_d = cnt_q;
      if (det) begin
         cnt_d = PW_C;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE_C;
      end
   end

   // Counter and registered pulse output; the output is high exactly while the next count is non-zero
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= (cnt_d != '0);
      end
   end

   assign out_o = out_q;

`ifdef EDGE_PULSE_CNT_EN
   logic [EVT_W-1:0] evt_q;

   // Saturating detected-edge counter; clear takes priority over a same-cycle detection
   always_ff @(posedge clk_i) begin
      if (rst_i || cnt_clr_i) begin
         evt_q <= '0;
      end else if (det && (evt_q != EVT_MAX)) begin
         evt_q <= evt_q + EVT_ONE;
      end
   end

   assign evt_cnt_o = evt_q;
`endif

endmodule

// File: rtl/edge_pulse_gen.sv
// rtl/edge_pulse_gen.sv - multi-channel edge-to-pulse generator top; EDGE_PULSE_CNT_EN adds per-channel event counters
module edge_pulse_gen
   import edge_pulse_pkg::*;
#(
   parameter int CH   = 4,
   parameter int SYNC = 2,
   parameter int PW   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic [CH-1:0]       in,
`ifdef EDGE_PULSE_CNT_EN
   input  logic                cnt_clr,
   output logic [CH*EVT_W-1:0] evt_cnt,
`endif
   output logic [CH-1:0]       out
);

   // One fully independent channel per input bit
   for (genvar i = 0; i < CH; i++) begin : g_ch
      edge_pulse_ch #(
         .SYNC (SYNC),
         .PW   (PW)
      ) u_ch (
         .clk_i     (clk),
         .rst_i     (rst),
         .en_i      (en),
         .mode_i    (mode),
         .in_i      (in[i]),
`ifdef EDGE_PULSE_CNT_EN
         .cnt_clr_i (cnt_clr),
         .evt_cnt_o (evt_cnt[EVT_W*i +: EVT_W]),
`endif
         .out_o     (out[i])
      );
   end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// tb/tb_edge_pulse_gen.sv - scoreboard bench for edge_pulse_gen (CH=4, SYNC=2, PW=4; counter checks when EDGE_PULSE_CNT_EN is defined)
module tb_edge_pulse_gen;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       en      = 1'b0;
   logic [1:0] mode    = 2'b00;
   logic [3:0] in_v    = 4'b0000;
   logic [3:0] out;
`ifdef EDGE_PULSE_CNT_EN
   logic        cnt_clr = 1'b0;
   logic [31:0] evt_cnt;
`endif

   always #5 clk = ~clk;

   edge_pulse_gen #(
      .CH   (4),
      .SYNC (2),
      .PW   (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .in      (in_v),
`ifdef EDGE_PULSE_CNT_EN
      .cnt_clr (cnt_clr),
      .evt_cnt (evt_cnt),
`endif
      .out     (out)
   );

   typedef struct {
      int          cyc;
      logic [3:0]  exp_o;
      bit          chk_o;
      logic [31:0] exp_c;
      bit          chk_c;
      int          ph;
   } sb_t;

   sb_t sb[$];
   int  cyc_cnt     = 0;
   int  vectors     = 0;
   int  miscompares = 0;
   int  phase       = 0;

   // Edge counter shared by stimulus (tagging) and monitor (matching)
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Push the expected state after the next rising edge, then advance one cycle
   task automatic tick(input logic [3:0] eo, input bit co, input logic [31:0] ec, input bit cc);
      sb_t e;
      e.cyc   = cyc_cnt + 1;
      e.exp_o = eo;
      e.chk_o = co;
      e.exp_c = ec;
      e.chk_c = cc;
      e.ph    = phase;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic t(input logic [3:0] eo);
      tick(eo, 1'b1, 32'd0, 1'b0);
   endtask

   task automatic tc(input logic [3:0] eo, input logic [31:0] ec);
      tick(eo, 1'b1, ec, 1'b1);
   endtask

   task automatic tn();
      tick(4'b0000, 1'b0, 32'd0, 1'b0);
   endtask

   // Monitor: at each falling edge compare every expectation tagged for the current cycle
   always @(negedge clk) begin : mon
      sb_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
         e = sb.pop_front();
         if (e.cyc < cyc_cnt) begin
            vectors++;
            miscompares++;
            $display("FAIL stale_entry phase=%0d tagged_cyc=%0d actual_cyc=%0d", e.ph, e.cyc, cyc_cnt);
         end else begin
            if (e.chk_o) begin
               vectors++;
               if (out !== e.exp_o) begin
                  miscompares++;
                  $display("FAIL out phase=%0d cyc=%0d actual=%b expected=%b", e.ph, e.cyc, out, e.exp_o);
               end
            end
`ifdef EDGE_PULSE_CNT_EN
            if (e.chk_c) begin
               vectors++;
               if (evt_cnt !== e.exp_c) begin
                  miscompares++;
                  $display("FAIL evt_cnt phase=%0d cyc=%0d actual=%h expected=%h", e.ph, e.cyc, evt_cnt, e.exp_c);
               end
            end
`endif
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;

      // Reset held for three cycles with inputs low
      phase = 1;
      repeat (3) tc(4'b0000, 32'd0);
      rst  = 1'b0;
      en   = 1'b1;
      mode = 2'b01;
      t(4'b0000);
      t(4'b0000);

      // Rising mode: pulse at n+2..n+5, falling edge ignored
      phase = 2;
      in_v = 4'b0001;
      t(4'b0000);
      t(4'b0000);
      repeat (4) t(4'b0001);
      t(4'b0000);
      t(4'b0000);
      in_v = 4'b0000;
      repeat (8) t(4'b0000);

      // Falling mode: rise ignored, fall pulses
      phase = 3;
      mode = 2'b10;
      in_v = 4'b0001;
      repeat (6) t(4'b0000);
      in_v = 4'b0000;
      t(4'b0000);
      t(4'b0000);
      repeat (4) t(4'b0001);
      t(4'b0000);
      t(4'b0000);

      // Both edges, retrigger: rise at n, fall at n+2 -> high n+2..n+7
      phase = 4;
      mode = 2'b11;
      in_v = 4'b0010;
      t(4'b0000);
      t(4'b0000);
      in_v = 4'b0000;
      repeat (6) t(4'b0010);
      t(4'b0000);
      t(4'b0000);

      // Simultaneous edges on channels 0 and 3
      phase = 5;
      in_v = 4'b1001;
      t(4'b0000);
      t(4'b0000);
      repeat (4) t(4'b1001);
      t(4'b0000);
      t(4'b0000);
      in_v = 4'b0000;
      t(4'b0000);
      t(4'b0000);
      repeat (4) t(4'b1001);
      t(4'b0000);
      t(4'b0000);

      // Enable low across an edge, then raised: no pulse at all
      phase = 6;
      mode = 2'b01;
      en   = 1'b0;
      in_v = 4'b0100;
      repeat (4) t(4'b0000);
      en = 1'b1;
      repeat (5) t(4'b0000);

      // Mode none behaves like disabled for both directions
      phase = 7;
      mode = 2'b00;
      in_v = 4'b0000;
      repeat (5) t(4'b0000);
      in_v = 4'b0100;
      repeat (5) t(4'b0000);
      mode = 2'b01;
      in_v = 4'b0000;
      repeat (4) t(4'b0000);

      // Reset during an active pulse, then input held high across release re-triggers
      phase = 8;
      in_v = 4'b0100;
      t(4'b0000);
      t(4'b0000);
      t(4'b0100);
      rst = 1'b1;
      t(4'b0000);
      t(4'b0000);
      rst = 1'b0;
      t(4'b0000);
      t(4'b0000);
      repeat (4) t(4'b0100);
      t(4'b0000);
      t(4'b0000);

`ifdef EDGE_PULSE_CNT_EN
      // Event counter: saturation at 255 after 300 rises, clear beats same-cycle detection
      phase = 9;
      rst  = 1'b1;
      in_v = 4'b0000;
      tc(4'b0000, 32'd0);
      rst = 1'b0;
      repeat (3) tc(4'b0000, 32'd0);
      for (int k = 0; k < 600; k++) begin
         in_v = (k % 2 == 0) ? 4'b1000 : 4'b0000;
         tn();
      end
      in_v = 4'b0000;
      tn();
      tn();
      repeat (3) tick(4'b0000, 1'b0, {8'd255, 24'd0}, 1'b1);

      phase = 10;
      in_v = 4'b1000;
      tc(4'b0000, {8'd255, 24'd0});
      tc(4'b0000, {8'd255, 24'd0});
      cnt_clr = 1'b1;
      tc(4'b1000, 32'd0);
      cnt_clr = 1'b0;
      tc(4'b1000, 32'd0);
      in_v = 4'b0000;
      tc(4'b1000, 32'd0);
      tc(4'b1000, 32'd0);
      t(4'b0000);
      repeat (2) t(4'b0000);
      in_v = 4'b1000;
      t(4'b0000);
      t(4'b0000);
      tc(4'b1000, 32'h0100_0000);
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/edge_pulse_gen.md
EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC, default 2, synchroniser stages per channel (2..4).
REQ-003 SHALL have parameter PW, default 4, output pulse width in clock cycles (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  detection enable.
REQ-007 SHALL have port mode  input  2  edge select: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 SHALL have port in  input  CH  asynchronous level inputs.
REQ-009 SHALL have port out  output  CH  registered per-channel pulse outputs.

Function
REQ-010 SHALL pass each in[i] through a SYNC-flop synchroniser, then one history flop (prev).
REQ-011 SHALL detect an edge on channel i when sync output differs from prev, the direction matches mode, and en=1.
REQ-012 SHALL assert out[i] at clock edge n+SYNC, where n is the first edge that samples the new input level.
REQ-013 SHALL hold out[i] high for exactly PW cycles after a single detected edge, then drive it low.
REQ-014 SHALL reload the channel width counter to PW on an edge detected during an active pulse, extending the pulse (retrigger), with no low gap.
REQ-015 SHALL use a per-channel down-counter of width $clog2(PW+1); no wrap below zero.
REQ-016 SHALL, with en=0, detect nothing; active pulses run to completion; synchroniser and prev keep updating, so raising en never creates a spurious edge.
REQ-017 SHALL apply mode and en changes to detections in the same cycle they are sampled; mode=00 equals en=0.
REQ-018 SHALL keep channels fully independent; simultaneous edges on several channels each produce their own pulse.

Reset
REQ-019 SHALL clear synchroniser flops, prev, counters and out to 0 on the clock edge where rst=1.
REQ-020 SHALL terminate any in-progress pulse at reset; out=0 from the first reset edge.
REQ-021 SHALL treat an input held high across reset release as a rising edge (prev resets to 0).

Configuration
REQ-022 SHALL, with macro EDGE_PULSE_CNT_EN defined, add input cnt_clr (1 bit) and output evt_cnt (CH*8 bits), one 8-bit saturating count of detected edges per channel, channel i at bits [8i+7:8i].
REQ-023 SHALL saturate evt_cnt at 255; cnt_clr and rst clear all counts to 0; cnt_clr wins over a same-cycle detection.
REQ-024 SHALL, without EDGE_PULSE_CNT_EN, omit cnt_clr, evt_cnt and the counters entirely; other behaviour unchanged.

Structure
REQ-025 SHALL place mode encodings (MODE_NONE, MODE_RISE, MODE_FALL, MODE_BOTH) and a 2-bit mode typedef in package edge_pulse_pkg.
REQ-026 SHALL implement one channel in sub-module edge_pulse_ch (synchroniser, prev, detector, width counter, optional event counter), instantiated CH times by generate.

Verification (CH=4, SYNC=2, PW=4)
REQ-027 SHALL test reset: rst=1 for 3 cycles, in=4'b0000 -> out=0, evt_cnt=0 throughout.
REQ-028 SHALL test rising mode: mode=01, in[0] 0->1 sampled at edge n -> out[0]=1 at edges n+2..n+5, 0 at n+6; later falling edge -> no pulse.
REQ-029 SHALL test retrigger: mode=11, in[1] rises at n, falls at n+2 -> out[1]=1 continuously n+2..n+7, 0 at n+8.
REQ-030 SHALL test enable/reset: en=0 during in[2] edge -> no pulse; rst=1 at n+3 of an active pulse -> out=0 from n+3.
REQ-031 SHALL test counter (macro on): 300 rising edges on in[3], mode=01 -> evt_cnt[31:24]=255; cnt_clr with same-cycle edge -> 0.
